// File: rtl/sid_bus_pkg.sv
// Shared types and constants for the SID bus controller.
package sid_bus_pkg;

  localparam int unsigned SID_DIV_BITS    = 3;
  localparam logic [4:0]  SID_REG_LAST_WR = 5'h18;
  localparam int unsigned SID_NUM_REGS    = 25;

  typedef enum logic [1:0] {
    StRstHold,
    StIdle,
    StSetup,
    StStrobe
  } sid_bus_state_e;

  // Registers above SID_REG_LAST_WR are read-only or unmapped on the SID.
  function automatic logic sid_addr_writable(input logic [4:0] addr);
    return addr <= SID_REG_LAST_WR;
  endfunction

endpackage

// File: rtl/sid_rr_arb2.sv
// Two-way round-robin grant; combinational, only active while enabled.
module sid_rr_arb2 (
  input  logic       i_valid_a,
  input  logic       i_valid_b,
  input  logic       i_en,
  input  logic       i_last_b,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      // A wins a contest only when B was the last one served.
      if (i_valid_a && (!i_valid_b || i_last_b)) begin
        o_grant = 2'b01;
      end else if (i_valid_b) begin
        o_grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/sid_bus_ctrl.sv
// SID chip bus controller: reset sequencing, two-requester write arbitration and strobe timing.
// Optional shadow register file enabled by defining SID_BUS_SHADOW_EN.
module sid_bus_ctrl
  import sid_bus_pkg::*;
#(
  parameter int unsigned RESET_SID_CLKS = 16
) (
  input  logic       C6_CLK_8MHZ,
  input  logic       RST_N,
  input  logic       soft_reset,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [4:0] a_addr,
  input  logic [7:0] a_data,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [4:0] b_addr,
  input  logic [7:0] b_data,
  output logic       busy,
  output logic       SID_CLK,
  output logic       SID_NOTCS,
  output logic       SID_NOTRES,
  output logic [4:0] SID_ADDR,
  output logic [7:0] SID_DATA
`ifdef SID_BUS_SHADOW_EN
  ,
  input  logic [4:0] shd_addr,
  output logic [7:0] shd_data
`endif
);

  localparam int unsigned CntW = $clog2(RESET_SID_CLKS + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(RESET_SID_CLKS - 1);

  localparam logic [SID_DIV_BITS-1:0] DivGrant   = SID_DIV_BITS'(1);
  localparam logic [SID_DIV_BITS-1:0] DivStrobe  = SID_DIV_BITS'(2);
  localparam logic [SID_DIV_BITS-1:0] DivRelease = SID_DIV_BITS'(0);
  localparam logic [SID_DIV_BITS-1:0] DivCount   = SID_DIV_BITS'(7);

  logic [SID_DIV_BITS-1:0] r_div;
  sid_bus_state_e          r_state;
  sid_bus_state_e          w_state_d;
  logic [CntW-1:0]         r_rst_cnt;
  logic [CntW-1:0]         w_rst_cnt_d;
  logic                    r_notres;
  logic                    w_notres_d;
  logic                    r_notcs;
  logic                    w_notcs_d;
  logic [4:0]              r_sid_addr;
  logic [4:0]              w_sid_addr_d;
  logic [7:0]              r_sid_data;
  logic [7:0]              w_sid_data_d;
  logic                    r_last_b;
  logic                    w_last_b_d;

  logic       w_arb_en;
  logic [1:0] w_grant;
  logic       w_hs_a;
  logic       w_hs_b;
  logic [4:0] w_hs_addr;
  logic [7:0] w_hs_data;

  assign w_arb_en = (r_state == StIdle) && (r_div == DivGrant);

  sid_rr_arb2 u_arb (
    .i_valid_a (a_valid),
    .i_valid_b (b_valid),
    .i_en      (w_arb_en),
    .i_last_b  (r_last_b),
    .o_grant   (w_grant)
  );

  assign a_ready   = w_grant[0];
  assign b_ready   = w_grant[1];
  assign w_hs_a    = a_valid & w_grant[0];
  assign w_hs_b    = b_valid & w_grant[1];
  assign w_hs_addr = w_hs_a ? a_addr : b_addr;
  assign w_hs_data = w_hs_a ? a_data : b_data;

  always_comb begin
    w_state_d    = r_state;
    w_rst_cnt_d  = r_rst_cnt;
    w_notres_d   = r_notres;
    w_notcs_d    = r_notcs;
    w_sid_addr_d = r_sid_addr;
    w_sid_data_d = r_sid_data;
    w_last_b_d   = r_last_b;

    // A handshake always consumes the request, so fairness tracks it regardless.
    if (w_hs_a || w_hs_b) begin
      w_last_b_d = w_hs_b;
    end

    if (soft_reset) begin
      w_state_d   = StRstHold;
      w_rst_cnt_d = '0;
      w_notres_d  = 1'b0;
      w_notcs_d   = 1'b1;
    end else begin
      unique case (r_state)
        StRstHold: begin
          w_notres_d = 1'b0;
          w_notcs_d  = 1'b1;
          if (r_div == DivCount) begin
            if (r_rst_cnt == CntLast) begin
              w_state_d   = StIdle;
              w_notres_d  = 1'b1;
              w_rst_cnt_d = '0;
            end else begin
              w_rst_cnt_d = r_rst_cnt + 1'b1;
            end
          end
        end
        StIdle: begin
          // Writes to read-only/unmapped registers are swallowed without a strobe.
          if ((w_hs_a || w_hs_b) && sid_addr_writable(w_hs_addr)) begin
            w_sid_addr_d = w_hs_addr;
            w_sid_data_d = w_hs_data;
            w_state_d    = StSetup;
          end
        end
        StSetup: begin
          if (r_div == DivStrobe) begin
            w_state_d = StStrobe;
            w_notcs_d = 1'b0;
          end
        end
        StStrobe: begin
          if (r_div == DivRelease) begin
            w_state_d = StIdle;
            w_notcs_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge C6_CLK_8MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_div      <= '0;
      r_state    <= StRstHold;
      r_rst_cnt  <= '0;
      r_notres   <= 1'b0;
      r_notcs    <= 1'b1;
      r_sid_addr <= '0;
      r_sid_data <= '0;
      r_last_b   <= 1'b1;
    end else begin
      r_div      <= r_div + SID_DIV_BITS'(1);
      r_state    <= w_state_d;
      r_rst_cnt  <= w_rst_cnt_d;
      r_notres   <= w_notres_d;
      r_notcs    <= w_notcs_d;
      r_sid_addr <= w_sid_addr_d;
      r_sid_data <= w_sid_data_d;
      r_last_b   <= w_last_b_d;
    end
  end

  assign busy       = (r_state != StIdle);
  assign SID_CLK    = r_div[SID_DIV_BITS-1];
  assign SID_NOTCS  = r_notcs;
  assign SID_NOTRES = r_notres;
  assign SID_ADDR   = r_sid_addr;
  assign SID_DATA   = r_sid_data;

`ifdef SID_BUS_SHADOW_EN
  logic [7:0] r_shadow [SID_NUM_REGS];

  // Shadow survives soft_reset so software can restore SID state afterwards.
  always_ff @(posedge C6_CLK_8MHZ or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(SID_NUM_REGS); i++) begin
        r_shadow[i] <= '0;
      end
    end else if ((r_state == StSetup) && !soft_reset) begin
      r_shadow[r_sid_addr] <= r_sid_data;
    end
  end

  assign shd_data = sid_addr_writable(shd_addr) ? r_shadow[shd_addr] : 8'h00;
`endif

endmodule

// File: tb/tb_sid_bus_ctrl.sv
// Self-checking bench for sid_bus_ctrl: directed scenarios plus randomized traffic
// against a timestamp-based reference model.
module tb_sid_bus_ctrl;

  localparam int RstClks = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_reset = 1'b0;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic [4:0] a_addr = '0;
  logic [4:0] b_addr = '0;
  logic [7:0] a_data = '0;
  logic [7:0] b_data = '0;
  logic       a_ready;
  logic       b_ready;
  logic       busy;
  logic       sid_clk;
  logic       sid_notcs;
  logic       sid_notres;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
`ifdef SID_BUS_SHADOW_EN
  logic [4:0] shd_addr = '0;
  logic [7:0] shd_data;
`endif

  sid_bus_ctrl #(
    .RESET_SID_CLKS (RstClks)
  ) dut (
    .C6_CLK_8MHZ (clk),
    .RST_N       (rst_n),
    .soft_reset  (soft_reset),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .busy        (busy),
    .SID_CLK     (sid_clk),
    .SID_NOTCS   (sid_notcs),
    .SID_NOTRES  (sid_notres),
    .SID_ADDR    (sid_addr),
    .SID_DATA    (sid_data)
`ifdef SID_BUS_SHADOW_EN
    ,
    .shd_addr    (shd_addr),
    .shd_data    (shd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: time is counted in clock edges since RST_N release; div is simply cyc mod 8.
  int         cyc;
  int         m_done;     // first edge index at which SID_NOTRES is high
  int         m_h;        // edge index of the last handshake that starts a strobe
  bit         m_last_b;
  bit         m_pend;
  logic [4:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_shd [32];

  bit hs_a, hs_b, dut_hs_a, dut_hs_b;
  int c_notres_lo, c_notcs_lo, c_ready_rst;
  bit gap_chk, seen_low;
  int hi_run;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int calc_done(input int s);
    int n = 0;
    for (int e = s + 1; e <= s + 8 * (RstClks + 1); e++) begin
      if ((e - 1) % 8 == 7) begin
        n++;
        if (n == RstClks) return e;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    cyc      = 0;
    m_done   = calc_done(0);
    m_h      = -100;
    m_last_b = 1'b1;
    m_pend   = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    for (int i = 0; i < 32; i++) m_shd[i] = '0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_notres", sid_notres, 0);
    check_eq("rst_notcs", sid_notcs, 1);
    check_eq("rst_addr", sid_addr, 0);
    check_eq("rst_data", sid_data, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_sidclk", sid_clk, 0);
    check_eq("rst_ready", a_ready | b_ready, 0);
  endtask

  // One clock: check everything between edges, then advance the model across the edge.
  task automatic tick();
    bit         busy_e, era, erb;
    int         e;
    logic [4:0] ad;
    logic [7:0] dt;
`ifdef SID_BUS_SHADOW_EN
    shd_addr = 5'($urandom_range(0, 31));
`endif
    #1;
    busy_e = (cyc < m_done) || (cyc >= m_h && cyc <= m_h + 6);
    era = !busy_e && (cyc % 8 == 1) && a_valid && (!b_valid || m_last_b);
    erb = !busy_e && (cyc % 8 == 1) && b_valid && (!a_valid || !m_last_b);
    check_eq("a_ready", a_ready, era);
    check_eq("b_ready", b_ready, erb);
    check_eq("busy", busy, busy_e);
    check_eq("sid_notres", sid_notres, cyc >= m_done);
    check_eq("sid_notcs", sid_notcs, !(cyc >= m_h + 1 && cyc <= m_h + 6));
    check_eq("sid_clk", sid_clk, (cyc % 8) >= 4);
    check_eq("sid_addr", sid_addr, m_addr);
    check_eq("sid_data", sid_data, m_data);
`ifdef SID_BUS_SHADOW_EN
    check_eq("shd_data", shd_data, m_shd[shd_addr]);
`endif
    if (!sid_notres) c_notres_lo++;
    if (!sid_notcs) c_notcs_lo++;
    if (!sid_notres && (a_ready || b_ready)) c_ready_rst++;
    dut_hs_a = a_valid && a_ready;
    dut_hs_b = b_valid && b_ready;
    if (sid_notcs) begin
      hi_run++;
    end else begin
      if (gap_chk && seen_low && hi_run > 0) check_eq("notcs_gap", hi_run, 2);
      hi_run   = 0;
      seen_low = 1'b1;
    end

    @(posedge clk);
    e    = cyc + 1;
    hs_a = era;
    hs_b = erb;
    if (era || erb) m_last_b = erb;
    if (soft_reset) begin
      m_done = calc_done(e);
      m_h    = -100;
      m_pend = 1'b0;
    end else begin
      if (m_pend && e == m_h + 1) begin
        m_shd[m_addr] = m_data;
        m_pend = 1'b0;
      end
      if (era || erb) begin
        ad = era ? a_addr : b_addr;
        dt = era ? a_data : b_data;
        if (ad <= 5'h18) begin
          m_addr = ad;
          m_data = dt;
          m_h    = e;
          m_pend = 1'b1;
        end
      end
    end
    cyc = e;
    #1;
  endtask

  task automatic wait_hs(input bit want_b, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      got = want_b ? dut_hs_b : dut_hs_a;
    end
    check_eq(tag, got, 1);
    if (want_b) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(25, 31));
    return 5'($urandom_range(0, 24));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit prev_b, have_prev;
    int n_gr;

    model_reset();
    #12;
    check_reset_values();
    #10 rst_n = 1'b1;

    // Request is already pending during the reset sequence; it must not be seen early.
    a_valid = 1'b1; a_addr = 5'h18; a_data = 8'h0F;
    c_notres_lo = 0; c_ready_rst = 0;
    wait_hs(1'b0, "first_hs");
    check_eq("notres_len", c_notres_lo, 128);
    check_eq("ready_in_rst", c_ready_rst, 0);
    c_notcs_lo = 0;
    repeat (12) tick();
    check_eq("strobe_len", c_notcs_lo, 6);
    check_eq("wr_addr", sid_addr, 5'h18);
    check_eq("wr_data", sid_data, 8'h0F);

    // Both requesters saturating the bus.
    a_valid = 1'b1; a_addr = 5'h01; a_data = 8'($urandom);
    b_valid = 1'b1; b_addr = 5'h02; b_data = 8'($urandom);
    gap_chk = 1'b1; seen_low = 1'b0; hi_run = 0; have_prev = 1'b0; n_gr = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if (dut_hs_a || dut_hs_b) begin
        n_gr++;
        if (have_prev) check_eq("rr_alt", dut_hs_b, !prev_b);
        prev_b = dut_hs_b; have_prev = 1'b1;
        a_data = 8'($urandom); b_data = 8'($urandom);
      end
    end
    check_eq("rr_grants", n_gr, 6);
    gap_chk = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (8) tick();

    // Unmapped register write is consumed silently.
    b_valid = 1'b1; b_addr = 5'h1B; b_data = 8'hAA;
    wait_hs(1'b1, "inv_hs");
    c_notcs_lo = 0;
    repeat (10) tick();
    check_eq("inv_no_strobe", c_notcs_lo, 0);
    check_eq("inv_addr_keep", sid_addr, m_addr);

    // Abort a strobe with soft_reset while SID_NOTCS is low at div 7.
    a_valid = 1'b1; a_addr = 5'h03; a_data = 8'h55;
    wait_hs(1'b0, "abort_hs");
    for (int i = 0; i < 16 && (cyc % 8 != 7); i++) tick();
    check_eq("abort_cs_low", sid_notcs, 0);
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_eq("abort_cs_high", sid_notcs, 1);
    c_notres_lo = 0; c_notcs_lo = 0; c_ready_rst = 0;
    repeat (140) tick();
    check_eq("soft_notres_len", c_notres_lo, 128);
    check_eq("soft_no_retry", c_notcs_lo, 0);
    check_eq("soft_ready_in_rst", c_ready_rst, 0);

`ifdef SID_BUS_SHADOW_EN
    a_valid = 1'b1; a_addr = 5'h04; a_data = 8'h21;
    wait_hs(1'b0, "shd_hs1");
    repeat (10) tick();
    shd_addr = 5'h04;
    #1 check_eq("shd_04_first", shd_data, 8'h21);
    a_valid = 1'b1; a_addr = 5'h04; a_data = 8'h20;
    wait_hs(1'b0, "shd_hs2");
    repeat (10) tick();
    shd_addr = 5'h04;
    #1 check_eq("shd_04_second", shd_data, 8'h20);
    shd_addr = 5'h1B;
    #1 check_eq("shd_1b_zero", shd_data, 8'h00);
`endif

    // Randomized traffic, then an asynchronous reset in the middle of it.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < (pass == 0 ? 3000 : 600); i++) begin
        if (a_valid && hs_a) a_valid = 1'b0;
        if (b_valid && hs_b) b_valid = 1'b0;
        if (!a_valid) begin
          if ($urandom_range(0, 3) == 0) begin
            a_valid = 1'b1; a_addr = rand_addr(); a_data = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          a_valid = 1'b0;
        end
        if (!b_valid) begin
          if ($urandom_range(0, 3) == 0) begin
            b_valid = 1'b1; b_addr = rand_addr(); b_data = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          b_valid = 1'b0;
        end
        soft_reset = ($urandom_range(0, 299) == 0);
        tick();
      end
      soft_reset = 1'b0;
      if (pass == 0) begin
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        #1 rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
